// File: rtl/clk_div_meter_pkg.sv
// Shared defaults and FSM state encoding for the slow-clock meter.
package clk_div_meter_pkg;

   localparam int CNT_W_DEF   = 32;
   localparam int TIMEOUT_DEF = 1_000_000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARM  = 2'd1,
      ST_MEAS = 2'd2
   } meter_state_t;

endpackage

// File: rtl/clk_div_meter_sync_edge_det.sv
// Synchroniser for an asynchronous slow input, plus rise/fall edge strobes.
// The flops carry no reset so that a reset never fabricates a false edge
// while the input happens to be high.
module sync_edge_det #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic i_sig,
   output logic o_s,
   output logic o_rise,
   output logic o_fall
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_s_d;

   // Shift the input through the synchroniser chain and keep a one-cycle delayed copy.
   always_ff @(posedge clk) begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_sig};
      r_s_d  <= r_sync[SYNC_STAGES-1];
   end

   assign o_s    = r_sync[SYNC_STAGES-1];
   assign o_rise = o_s & ~r_s_d;
   assign o_fall = ~o_s & r_s_d;

endmodule

// File: rtl/clk_div_meter.sv
// Measures period, high time and equivalent divisor of a slow square wave
// relative to clk, with lock and sticky timeout indication.
module clk_div_meter
   import clk_div_meter_pkg::*;
#(
   parameter int CNT_W       = CNT_W_DEF,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = TIMEOUT_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             sig_in,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic [CNT_W-1:0] div_n_est,
   output logic             meas_valid,
   output logic             locked,
   output logic             timeout
);

   localparam logic [CNT_W-1:0] TO_V  = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] ONE_V = CNT_W'(1);

   logic w_s;
   logic w_rise;
   logic w_fall;

   meter_state_t     r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_high_pend;
   logic [CNT_W-1:0] r_period;
   logic [CNT_W-1:0] r_high_time;
   logic [CNT_W-1:0] r_div_n_est;
   logic             r_meas_valid;
   logic             r_locked;
   logic             r_timeout;
   logic             r_have_prev;

   sync_edge_det #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .i_sig (sig_in),
      .o_s   (w_s),
      .o_rise(w_rise),
      .o_fall(w_fall)
   );

   // Measurement FSM: arm on a rise, count clk cycles between rises, publish on each rise.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_cnt        <= '0;
         r_high_pend  <= '0;
         r_period     <= '0;
         r_high_time  <= '0;
         r_div_n_est  <= '0;
         r_meas_valid <= 1'b0;
         r_locked     <= 1'b0;
         r_timeout    <= 1'b0;
         r_have_prev  <= 1'b0;
      end else if (!en) begin
         // Disable beats a coincident rise; published measurements are kept.
         r_state      <= ST_IDLE;
         r_cnt        <= '0;
         r_meas_valid <= 1'b0;
         r_locked     <= 1'b0;
         r_timeout    <= 1'b0;
         r_have_prev  <= 1'b0;
      end else begin
         r_meas_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_have_prev <= 1'b0;
               r_state     <= ST_ARM;
            end
            ST_ARM: begin
               if (w_rise) begin
                  r_cnt     <= ONE_V;
                  r_timeout <= 1'b0;
                  r_state   <= ST_MEAS;
               end
            end
            ST_MEAS: begin
               if (w_fall) begin
                  r_high_pend <= r_cnt;
               end
               // A rise on the same cycle cnt reaches TIMEOUT still publishes.
               if (w_rise && w_s) begin
                  r_period     <= r_cnt;
                  r_high_time  <= r_high_pend;
                  r_div_n_est  <= r_cnt - ONE_V;
                  r_meas_valid <= 1'b1;
                  r_locked     <= r_have_prev && (r_cnt == r_period);
                  r_have_prev  <= 1'b1;
                  r_cnt        <= ONE_V;
               end else if (r_cnt == TO_V) begin
                  // cnt stays parked at TIMEOUT; the lock history restarts.
                  r_timeout   <= 1'b1;
                  r_locked    <= 1'b0;
                  r_have_prev <= 1'b0;
                  r_state     <= ST_ARM;
               end else begin
                  r_cnt <= r_cnt + ONE_V;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign period     = r_period;
   assign high_time  = r_high_time;
   assign div_n_est  = r_div_n_est;
   assign meas_valid = r_meas_valid;
   assign locked     = r_locked;
   assign timeout    = r_timeout;

endmodule

// File: tb/tb_clk_div_meter.sv
// Directed bench for clk_div_meter: an in-bench clk_div style generator drives
// sig_in; outputs are sampled 1 time unit after each rising clk edge.
module tb_clk_div_meter;

   localparam int CNT_W = 32;
   localparam int TO    = 100;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             en = 1'b0;
   logic             sig_in = 1'b0;
   logic [CNT_W-1:0] period;
   logic [CNT_W-1:0] high_time;
   logic [CNT_W-1:0] div_n_est;
   logic             meas_valid;
   logic             locked;
   logic             timeout;

   int n_checks = 0;
   int n_err    = 0;

   // Generator: period gen_p (0 = hold low), high for ceil(gen_p/2) cycles.
   int   gen_p     = 0;
   int   gen_cnt   = 0;
   int   gen_rises = 0;
   logic gen_nxt;

   clk_div_meter #(
      .CNT_W      (CNT_W),
      .SYNC_STAGES(2),
      .TIMEOUT    (TO)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .sig_in    (sig_in),
      .period    (period),
      .high_time (high_time),
      .div_n_est (div_n_est),
      .meas_valid(meas_valid),
      .locked    (locked),
      .timeout   (timeout)
   );

   always #5 clk = ~clk;

   initial begin
      forever begin
         @(negedge clk);
         if (gen_p == 0) begin
            gen_nxt = 1'b0;
            gen_cnt = 0;
         end else begin
            gen_nxt = (gen_cnt < (gen_p + 1) / 2);
            gen_cnt = (gen_cnt + 1 >= gen_p) ? 0 : gen_cnt + 1;
         end
         if (gen_nxt && !sig_in) gen_rises++;
         sig_in = gen_nxt;
      end
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_pub(input string tag, input int max_cyc, output int waited);
      waited = 0;
      do begin
         step();
         waited++;
      end while (!meas_valid && waited < max_cyc);
      if (!meas_valid) chk({tag, "_wait"}, 32'(meas_valid), 32'd1);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_period"}, period, 0);
      chk({tag, "_high"}, high_time, 0);
      chk({tag, "_div"}, div_n_est, 0);
      chk({tag, "_valid"}, 32'(meas_valid), 0);
      chk({tag, "_locked"}, 32'(locked), 0);
      chk({tag, "_timeout"}, 32'(timeout), 0);
   endtask

   initial begin
      int w;
      int base;
      logic seen;

      // Reset state
      repeat (3) step();
      chk_zero("rst");

      // Divide-by-10 source: first publish on the 2nd rise, lock on the next
      rst_n = 1'b1;
      en    = 1'b1;
      gen_p = 10;
      wait_pub("t1a", 60, w);
      chk("t1a_period", period, 10);
      chk("t1a_high", high_time, 5);
      chk("t1a_div", div_n_est, 9);
      chk("t1a_locked", 32'(locked), 0);
      step();
      chk("t1_pulse_width", 32'(meas_valid), 0);
      wait_pub("t1b", 20, w);
      chk("t1_spacing", w + 1, 10);
      chk("t1b_period", period, 10);
      chk("t1b_locked", 32'(locked), 1);

      // Fastest legal input: period 2
      gen_p = 2;
      wait_pub("t2s1", 30, w);
      wait_pub("t2s2", 30, w);
      wait_pub("t2a", 30, w);
      chk("t2_period", period, 2);
      chk("t2_high", high_time, 1);
      chk("t2_div", div_n_est, 1);
      chk("t2a_locked", 32'(locked), 1);
      wait_pub("t2b", 10, w);
      chk("t2_spacing", w, 2);
      chk("t2b_locked", 32'(locked), 1);

      // Divisor change 9 -> 4 while locked
      gen_p = 10;
      wait_pub("t3s1", 30, w);
      wait_pub("t3s2", 30, w);
      wait_pub("t3a", 30, w);
      chk("t3a_period", period, 10);
      chk("t3a_locked", 32'(locked), 1);
      gen_p = 5;
      wait_pub("t3b", 30, w);
      chk("t3_trans_locked", 32'(locked), 0);
      wait_pub("t3c", 30, w);
      chk("t3c_period", period, 5);
      chk("t3c_high", high_time, 3);
      chk("t3c_div", div_n_est, 4);
      chk("t3c_locked", 32'(locked), 1);

      // Period equal to TIMEOUT: the rise wins over the timeout
      gen_p = 100;
      wait_pub("t6a", 250, w);
      wait_pub("t6b", 250, w);
      chk("t6_period", period, 100);
      chk("t6_high", high_time, 50);
      chk("t6_div", div_n_est, 99);
      chk("t6_timeout", 32'(timeout), 0);
      chk("t6_locked", 32'(locked), 1);

      // Period one beyond TIMEOUT: times out, last period is held
      gen_p = 101;
      w = 0;
      do begin
         step();
         w++;
      end while (!timeout && w < 150);
      chk("t6x_timeout", 32'(timeout), 1);
      chk("t6x_period", period, 100);

      // Input stops after a rise: timeout exactly when cnt reaches TIMEOUT
      gen_p = 10;
      wait_pub("t4s1", 250, w);
      wait_pub("t4s2", 30, w);
      wait_pub("t4a", 30, w);
      chk("t4a_locked", 32'(locked), 1);
      gen_p = 0;
      seen = 1'b0;
      for (int i = 1; i < TO; i++) begin
         step();
         if (timeout) seen = 1'b1;
      end
      chk("t4_early_timeout", 32'(seen), 0);
      step();
      chk("t4_timeout", 32'(timeout), 1);
      chk("t4_locked", 32'(locked), 0);
      chk("t4_period_held", period, 10);
      gen_p = 10;
      seen = 1'b0;
      w = 0;
      do begin
         step();
         w++;
         if (meas_valid) seen = 1'b1;
      end while (timeout && w < 30);
      chk("t4_rearm_timeout", 32'(timeout), 0);
      chk("t4_rearm_no_pub", 32'(seen), 0);
      wait_pub("t4b", 30, w);
      chk("t4b_period", period, 10);
      chk("t4b_locked", 32'(locked), 0);
      chk("t4b_timeout", 32'(timeout), 0);

      // Reset pulse in the middle of a measurement
      wait_pub("t5s", 30, w);
      repeat (3) step();
      rst_n = 1'b0;
      step();
      chk_zero("t5_rst");
      rst_n = 1'b1;
      base  = gen_rises;
      wait_pub("t5a", 60, w);
      chk("t5a_rises", gen_rises - base, 2);
      chk("t5a_period", period, 10);
      chk("t5a_locked", 32'(locked), 0);

      // Enable dropped for 3 cycles: flags clear, measurements held
      wait_pub("t5b", 30, w);
      en = 1'b0;
      repeat (3) step();
      chk("t5_en_valid", 32'(meas_valid), 0);
      chk("t5_en_locked", 32'(locked), 0);
      chk("t5_en_timeout", 32'(timeout), 0);
      chk("t5_en_period", period, 10);
      chk("t5_en_high", high_time, 5);
      chk("t5_en_div", div_n_est, 9);
      en   = 1'b1;
      base = gen_rises;
      wait_pub("t5c", 60, w);
      chk("t5c_rises", gen_rises - base, 2);
      chk("t5c_period", period, 10);
      chk("t5c_locked", 32'(locked), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
